// File: rtl/cls_pkg.sv
// cls_pkg: shared types and constants for the lockstep vote handler.
package cls_pkg;

    localparam int CLS_CMP_WIDTH = 104;

    localparam logic [1:0] CLS_ST_RUN   = 2'd0;
    localparam logic [1:0] CLS_ST_RESET = 2'd1;
    localparam logic [1:0] CLS_ST_FATAL = 2'd2;

    typedef enum logic [1:0] {
        CLS_RUN   = CLS_ST_RUN,
        CLS_RESET = CLS_ST_RESET,
        CLS_FATAL = CLS_ST_FATAL
    } cls_state_e;

endpackage

// File: rtl/cls_majority.sv
// cls_majority: bitwise TMR majority (or DMR channel 0) and per-channel disagree flags.
module cls_majority #(
    parameter int N_CH  = 3,
    parameter int WIDTH = 104
) (
    input  logic [N_CH*WIDTH-1:0] ch_i,
    output logic [WIDTH-1:0]      voted_o,
    output logic [N_CH-1:0]       disagree_o
);

    if (N_CH == 3) begin : g_tmr
        assign voted_o = (ch_i[0+:WIDTH] & ch_i[WIDTH+:WIDTH])
                       | (ch_i[0+:WIDTH] & ch_i[2*WIDTH+:WIDTH])
                       | (ch_i[WIDTH+:WIDTH] & ch_i[2*WIDTH+:WIDTH]);
    end else begin : g_dmr
        assign voted_o = ch_i[0+:WIDTH];
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_dis
        assign disagree_o[k] = |(ch_i[k*WIDTH+:WIDTH] ^ voted_o);
    end

endmodule

// File: rtl/cls_vote_handler.sv
// cls_vote_handler: lockstep compare, error bookkeeping and core reset/fatal sequencing.
module cls_vote_handler
    import cls_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int WIDTH      = CLS_CMP_WIDTH,
    parameter int MAX_RETRY  = 3,
    parameter int RST_CYCLES = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_CH*WIDTH-1:0]          ch_i,
    input  logic                           cmp_en_i,
    input  logic                           clear_i,
    output logic [WIDTH-1:0]               voted_o,
    output logic                           mismatch_o,
    output logic [N_CH-1:0]                fault_ch_o,
    output logic [15:0]                    err_cnt_o,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o,
    output logic                           core_rst_no,
    output logic                           fatal_o,
    output logic [1:0]                     state_o
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int CW = $clog2(RST_CYCLES);

    logic [N_CH-1:0] dis;
    logic [1:0]      n_dis;
    logic            corr, uncorr;
    cls_state_e      state_q, state_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic            mism_q, mism_d, crst_q, crst_d;
    logic [N_CH-1:0] fault_q, fault_d;
    logic [15:0]     err_q, err_d;
    logic [RW-1:0]   retry_q, retry_d;

    cls_majority #(.N_CH(N_CH), .WIDTH(WIDTH)) u_maj (
        .ch_i      (ch_i),
        .voted_o   (voted_o),
        .disagree_o(dis)
    );

    always_comb begin
        n_dis = '0;
        for (int k = 0; k < N_CH; k++) n_dis = n_dis + {1'b0, dis[k]};
    end

    // A lone dissenter is only maskable with three channels; DMR cannot tell who is right.
    assign corr   = (N_CH == 3) && (n_dis == 2'd1);
    assign uncorr = (n_dis != 2'd0) && !corr;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        mism_d  = 1'b0;
        fault_d = clear_i ? '0 : fault_q;
        err_d   = clear_i ? '0 : err_q;
        retry_d = clear_i ? '0 : retry_q;
        case (state_q)
            CLS_RUN: begin
                if (cmp_en_i && (corr || uncorr)) begin
                    mism_d = 1'b1;
                    err_d  = (err_d == 16'hFFFF) ? err_d : err_d + 16'd1;
                end
                if (cmp_en_i && corr) fault_d = fault_d | dis;
                if (cmp_en_i && uncorr) begin
                    if (retry_d < RW'(MAX_RETRY)) begin
                        retry_d = retry_d + 1'b1;
                        state_d = CLS_RESET;
                        rcnt_d  = '0;
                    end else begin
                        state_d = CLS_FATAL;
                    end
                end
            end
            CLS_RESET: begin
                state_d = (rcnt_q == CW'(RST_CYCLES - 1)) ? CLS_RUN : CLS_RESET;
                rcnt_d  = rcnt_q + 1'b1;
            end
            CLS_FATAL: begin
                state_d = clear_i ? CLS_RESET : CLS_FATAL;
                rcnt_d  = '0;
            end
            default: state_d = CLS_FATAL;
        endcase
        crst_d = (state_d == CLS_RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CLS_RUN;
            rcnt_q  <= '0;
            mism_q  <= 1'b0;
            crst_q  <= 1'b0;
            fault_q <= '0;
            err_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            mism_q  <= mism_d;
            crst_q  <= crst_d;
            fault_q <= fault_d;
            err_q   <= err_d;
            retry_q <= retry_d;
        end
    end

    assign mismatch_o  = mism_q;
    assign fault_ch_o  = fault_q;
    assign err_cnt_o   = err_q;
    assign retry_cnt_o = retry_q;
    assign core_rst_no = crst_q;
    assign fatal_o     = (state_q == CLS_FATAL);
    assign state_o     = state_q;

endmodule

// File: doc/cls_vote_handler.md
CLS_VOTE_HANDLER -- requirements
Module: cls_vote_handler

Interface
REQ-001 SHALL have parameter N_CH, default 3, number of lockstep channels compared; legal values 2 (DMR) and 3 (TMR).
REQ-002 SHALL have parameter WIDTH, default 104, compared bits per channel: instr_req+instr_addr+data_req+data_we+data_be+data_addr+data_wdata+core_busy.
REQ-003 SHALL have parameter MAX_RETRY, default 3, number of core resets allowed before fatal.
REQ-004 SHALL have parameter RST_CYCLES, default 8, core reset pulse length in cycles, minimum 2.
REQ-005 clk_i  in  1  single clock.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 ch_i  in  N_CH*WIDTH  packed channel outputs; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 cmp_en_i  in  1  compare enable; 0 masks all checking.
REQ-009 clear_i  in  1  clears sticky status and retry count.
REQ-010 voted_o  out  WIDTH  combinational bitwise majority (TMR) or channel 0 (DMR).
REQ-011 mismatch_o  out  1  registered: a compare failed last cycle.
REQ-012 fault_ch_o  out  N_CH  sticky, bit k = channel k was the lone disagreeing channel.
REQ-013 err_cnt_o  out  16  saturating count of mismatch cycles.
REQ-014 retry_cnt_o  out  clog2(MAX_RETRY+1)  core resets issued since clear.
REQ-015 core_rst_no  out  1  active-low reset to all channel cores.
REQ-016 fatal_o  out  1  permanent fault.
REQ-017 state_o  out  2  current FSM state encoding.

Function
REQ-018 Channel k SHALL be disagreeing when its slice differs from voted_o in any bit; classification is by count of disagreeing channels: 0 clean, 1 correctable (TMR only), 2 or more uncorrectable; in DMR any difference is uncorrectable.
REQ-019 Comparison SHALL be performed only in state RUN with cmp_en_i=1; otherwise the cycle is treated as clean.
REQ-020 FSM states: RUN=0, RESET=1, FATAL=2; encoding 3 unused and SHALL recover to FATAL.
REQ-021 RUN, clean: SHALL remain RUN, mismatch_o=0 next cycle.
REQ-022 RUN, correctable: SHALL remain RUN, voted_o keeps masking the faulty channel; next cycle mismatch_o=1, fault_ch_o bit set, err_cnt_o +1.
REQ-023 RUN, uncorrectable, retry_cnt_o < MAX_RETRY: next cycle state RESET, mismatch_o=1, err_cnt_o +1, retry_cnt_o +1, core_rst_no=0.
REQ-024 RUN, uncorrectable, retry_cnt_o = MAX_RETRY: next cycle state FATAL, fatal_o=1, core_rst_no=0, err_cnt_o +1.
REQ-025 RESET SHALL hold core_rst_no=0 for exactly RST_CYCLES cycles, then return to RUN with core_rst_no=1 in the same cycle as the state change.
REQ-026 FATAL SHALL hold core_rst_no=0 and fatal_o=1 until clear_i=1; then the next cycle enters RESET with retry_cnt_o=0 and fatal_o=0.
REQ-027 clear_i in RUN or RESET SHALL zero fault_ch_o, err_cnt_o, retry_cnt_o next cycle, with no state change.
REQ-028 clear_i coincident with a mismatch: the clear applies first, then the new event, e.g. err_cnt_o=1, and retry_cnt_o=1 if uncorrectable.
REQ-029 err_cnt_o SHALL saturate at 16'hFFFF with no wrap.
REQ-030 mismatch_o SHALL be 0 in every cycle following a non-compared cycle.

Reset
REQ-031 Asynchronous reset SHALL set state RUN, mismatch_o=0, fault_ch_o=0, err_cnt_o=0, retry_cnt_o=0, fatal_o=0, core_rst_no=0.
REQ-032 core_rst_no SHALL deassert on the first clk_i edge after rst_ni rises, giving a synchronous release to the cores.
REQ-033 Reset asserted mid-RESET or mid-FATAL SHALL abort that state immediately, with no residual count.

Structure
REQ-034 Shared package cls_pkg SHALL hold the cls_state_e enum, the constant CLS_CMP_WIDTH=104, and the state_o encodings.
REQ-035 Voting SHALL be a combinational sub-module cls_majority (parameters N_CH and WIDTH) producing the voted word and the N_CH disagree vector; all state lives in cls_vote_handler.

Verification
REQ-036 TMR, all three channels 0x...A5 for 100 cycles -> mismatch_o=0, err_cnt_o=0, core_rst_no=1 throughout.
REQ-037 TMR, channel 1 bit 3 flipped for one cycle -> voted_o unchanged, mismatch_o=1 one cycle later, fault_ch_o=3'b010, err_cnt_o=1, state RUN.
REQ-038 TMR, ch0≠ch1≠ch2 -> state RESET, core_rst_no low for exactly 8 cycles, retry_cnt_o=1, then RUN.
REQ-039 DMR, four uncorrectable events with MAX_RETRY=3 -> retry_cnt_o=3, then FATAL with fatal_o=1; clear_i -> RESET, retry_cnt_o=0, then RUN after 8 cycles.
REQ-040 cmp_en_i=0 while channels differ -> no flags, no reset; clear_i coincident with a correctable error -> err_cnt_o=1.
REQ-041 err_cnt_o preloaded to 16'hFFFE via 2 more correctable events -> holds at 16'hFFFF; rst_ni pulse mid-RESET -> all outputs at reset values immediately.
